seq_mult_param: RTL and testbench

//  Parametrised sequential shift-add multiplier; next generation of our smart binary multiplier.
//  - Adds per-operation signed/unsigned mode, exact early termination and a registered product.
//  - Adds a one-cycle done pulse.
//  - Sits as a low-area multiply unit behind a simple start/rdy handshake.

---
 rtl/seq_mult_param.sv | 136 +++++++++++++
 tb/tb_seq_mult_param.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_param.sv
// Sequential shift-add multiplier with signed/unsigned mode and exact early termination.
// Latency: 2 cycles for a zero operand, else 2 + 2n (+1 to negate), n = msb index of |multiplier| + 1.
// Backpressure: start is only accepted while rdy=1; start during a busy cycle is dropped, not queued.
module seq_mult_param #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 rdy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0]   ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [2*WIDTH-1:0] ONE_2W  = {{(2*WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   ONE_CNT = CNT_W'(1);
  localparam logic [CNT_W-1:0]   P_INIT  = CNT_W'(WIDTH);

  typedef enum logic [2:0] {
    S_idle,
    S_check,
    S_add,
    S_shift,
    S_fix,
    S_done
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   mc_q, mc_d;
  logic [WIDTH-1:0]     mq_q, mq_d;
  logic                 neg_q, neg_d;
  logic [CNT_W-1:0]     p_q, p_d;
  logic                 rdy_q, rdy_d;
  logic                 done_q, done_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  // Magnitude as a W-bit unsigned value; the most negative input maps to 2^(W-1), which still fits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sm);
    return (sm && x[WIDTH-1]) ? (~x + ONE_W) : x;
  endfunction

  // Next-state and datapath: one add-or-skip step and one shift step per multiplier bit.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mc_d      = mc_q;
    mq_d      = mq_q;
    neg_d     = neg_q;
    p_d       = p_q;
    case (state_q)
      S_idle: begin
        if (start) begin
          mc_d    = {{WIDTH{1'b0}}, magnitude(multiplicand, signed_mode)};
          mq_d    = magnitude(multiplier, signed_mode);
          acc_d   = '0;
          p_d     = P_INIT;
          neg_d   = signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
          state_d = S_check;
        end
      end
      S_check: begin
        state_d = ((mc_q == '0) || (mq_q == '0)) ? S_done : S_add;
      end
      S_add: begin
        if (mq_q[0]) acc_d = acc_q + mc_q;
        p_d     = p_q - ONE_CNT;
        state_d = S_shift;
      end
      S_shift: begin
        mc_d = mc_q << 1;
        mq_d = mq_q >> 1;
        // Multiplicand is pre-aligned by shifting, so stopping once MQ runs out is exact.
        if ((mq_d == '0) || (p_q == '0)) state_d = neg_q ? S_fix : S_done;
        else                             state_d = S_add;
      end
      S_fix: begin
        acc_d   = ~acc_q + ONE_2W;
        state_d = S_done;
      end
      S_done: begin
        state_d = S_idle;
      end
      default: begin
        state_d = S_idle;
      end
    endcase
    // Outputs are registered from the next state so done and the new product appear together.
    rdy_d     = (state_d == S_idle);
    done_d    = (state_d == S_done);
    product_d = (state_d == S_done) ? acc_d : product_q;
  end

  // State and output registers with synchronous reset; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_idle;
      acc_q     <= '0;
      mc_q      <= '0;
      mq_q      <= '0;
      neg_q     <= 1'b0;
      p_q       <= '0;
      rdy_q     <= 1'b1;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mc_q      <= mc_d;
      mq_q      <= mq_d;
      neg_q     <= neg_d;
      p_q       <= p_d;
      rdy_q     <= rdy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  assign rdy     = rdy_q;
  assign done    = done_q;
  assign product = product_q;

  // The bit counter must never be decremented past zero.
  p_no_underflow: assert property (@(posedge clk) disable iff (rst)
    (state_q == S_add) |-> (p_q != '0));

  // When the counter is exhausted only bit 0 of MQ can remain, so the shift empties it.
  mq_empty_at_end: assert property (@(posedge clk) disable iff (rst)
    ((state_q == S_shift) && (p_q == '0)) |-> (mq_q[WIDTH-1:1] == '0));

endmodule

// File: tb/tb_seq_mult_param.sv
// Directed bench for seq_mult_param at WIDTH=8.
// Latency is counted with the accepting edge as 0; cycle k is observed just after edge k-1.
// Every expected product and latency below is hand-computed.
module tb_seq_mult_param;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           signed_mode;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           rdy;
  logic           done;
  logic [2*W-1:0] product;

  int checks = 0;
  int errors = 0;

  seq_mult_param #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .signed_mode  (signed_mode),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .rdy          (rdy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  // One operation; entered and left #1 after a rising edge with the DUT idle.
  task automatic run_op(input string name, input logic sm, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [2*W-1:0] exp_p, input int exp_lat);
    int lat;
    checks++;
    if (rdy !== 1'b1) begin
      errors++;
      $display("FAIL %s rdy_before: got %b required 1", name, rdy);
    end
    signed_mode  = sm;
    multiplicand = a;
    multiplier   = b;
    start        = 1'b1;
    @(posedge clk); #1;
    start        = 1'b0;
    multiplicand = ~a;
    multiplier   = ~b;
    signed_mode  = ~sm;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        lat = k + 1;
        break;
      end
    end
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d required %0d", name, lat, exp_lat);
    end
    checks++;
    if (product !== exp_p) begin
      errors++;
      $display("FAIL %s product: got %h required %h", name, product, exp_p);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || rdy !== 1'b1) begin
      errors++;
      $display("FAIL %s after_done: got done=%b rdy=%b required done=0 rdy=1", name, done, rdy);
    end
    checks++;
    if (product !== exp_p) begin
      errors++;
      $display("FAIL %s product_hold: got %h required %h", name, product, exp_p);
    end
  endtask

  task automatic wait_idle(input string name);
    int seen;
    seen = 0;
    for (int k = 0; k < 60; k++) begin
      if (rdy === 1'b1) begin
        seen = 1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++;
    if (seen != 1) begin
      errors++;
      $display("FAIL %s wait_idle: got rdy=%b required 1 within 60 cycles", name, rdy);
    end
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    start        = 1'b1;
    signed_mode  = 1'b0;
    multiplicand = 8'd5;
    multiplier   = 8'd5;
    @(posedge clk); @(posedge clk); #1;
    checks++;
    if (rdy !== 1'b1 || done !== 1'b0 || product !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b done=%b product=%h required rdy=1 done=0 product=0000",
               rdy, done, product);
    end
    rst   = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rdy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got rdy=%b done=%b required rdy=1 done=0", rdy, done);
    end
  endtask

  task automatic test_unsigned();
    run_op("u13x11", 1'b0, 8'd13, 8'd11, 16'h008F, 10);
    run_op("u255x1", 1'b0, 8'hFF, 8'h01, 16'h00FF, 4);
  endtask

  task automatic test_signed();
    run_op("s-3x5", 1'b1, 8'hFD, 8'h05, 16'hFFF1, 9);
    run_op("s-1x-1", 1'b1, 8'hFF, 8'hFF, 16'h0001, 4);
  endtask

  task automatic test_zero();
    run_op("u0x200", 1'b0, 8'd0, 8'd200, 16'h0000, 2);
    run_op("s200x0", 1'b1, 8'd200, 8'd0, 16'h0000, 2);
    run_op("s0x200", 1'b1, 8'd0, 8'd200, 16'h0000, 2);
    run_op("u1x1", 1'b0, 8'd1, 8'd1, 16'h0001, 4);
  endtask

  task automatic test_extremes();
    run_op("u255x255", 1'b0, 8'hFF, 8'hFF, 16'hFE01, 18);
    run_op("s-128x-128", 1'b1, 8'h80, 8'h80, 16'h4000, 18);
    run_op("s-128x127", 1'b1, 8'h80, 8'h7F, 16'hC080, 17);
  endtask

  // start held high: 2*3 accepted at edge 0, 9*9 accepted when the DUT next idles.
  task automatic test_back_to_back();
    int done_cnt, rdy_cnt, first_k, second_k, wide;
    logic [2*W-1:0] p1, p2;
    logic prev_done;
    done_cnt = 0; rdy_cnt = 0; first_k = 0; second_k = 0; wide = 0;
    p1 = '0; p2 = '0; prev_done = 1'b0;
    signed_mode  = 1'b0;
    multiplicand = 8'd2;
    multiplier   = 8'd3;
    start        = 1'b1;
    @(posedge clk); #1;
    multiplicand = 8'd9;
    multiplier   = 8'd9;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (rdy === 1'b1) rdy_cnt++;
      if (done === 1'b1) begin
        if (prev_done) wide++;
        done_cnt++;
        if (done_cnt == 1) begin first_k = k; p1 = product; end
        if (done_cnt == 2) begin second_k = k; p2 = product; end
      end
      prev_done = done;
    end
    start = 1'b0;
    checks++;
    if (done_cnt != 2 || rdy_cnt != 2) begin
      errors++;
      $display("FAIL b2b_counts: got done=%0d rdy=%0d required done=2 rdy=2", done_cnt, rdy_cnt);
    end
    checks++;
    if (first_k != 5 || p1 !== 16'h0006) begin
      errors++;
      $display("FAIL b2b_first: got k=%0d product=%h required k=5 product=0006", first_k, p1);
    end
    checks++;
    if (second_k != 16 || p2 !== 16'h0051) begin
      errors++;
      $display("FAIL b2b_second: got k=%0d product=%h required k=16 product=0051", second_k, p2);
    end
    checks++;
    if (wide != 0) begin
      errors++;
      $display("FAIL b2b_done_width: got %0d wide pulses required 0", wide);
    end
    wait_idle("b2b");
  endtask

  task automatic test_reset_mid_op();
    int done_cnt;
    done_cnt = 0;
    signed_mode  = 1'b0;
    multiplicand = 8'hFF;
    multiplier   = 8'hFF;
    start        = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (rdy !== 1'b1 || done !== 1'b0 || product !== 16'h0000) begin
      errors++;
      $display("FAIL midop_reset: got rdy=%b done=%b product=%h required rdy=1 done=0 product=0000",
               rdy, done, product);
    end
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) done_cnt++;
    end
    checks++;
    if (done_cnt != 0) begin
      errors++;
      $display("FAIL midop_no_done: got %0d done pulses required 0", done_cnt);
    end
    run_op("u2x3_after_rst", 1'b0, 8'd2, 8'd3, 16'h0006, 6);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_zero();
    test_extremes();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
